// File: rtl/vecmat32_loader_if.sv
// Element-pair handshake into the vecmat32 operand loader.
// Master offers a vector/matrix element pair; slave accepts on valid & ready.
interface vecmat32_loader_if #(
    parameter int ELEM_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_vec;
    logic [ELEM_W-1:0] in_mat;

    modport master (
        output in_valid,
        output in_vec,
        output in_mat,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  in_mat,
        output in_ready
    );
endinterface

// File: rtl/vecmat32_loader.sv
// Collects DEPTH element pairs into packed operands for the vecmat32 stage
// and captures that stage's result a fixed latency after each launch.
module vecmat32_loader #(
    parameter int ELEM_W     = 16,
    parameter int DEPTH      = 32,
    parameter int RESULT_LAT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    vecmat32_loader_if.slave        in_bus,
    output logic [DEPTH*ELEM_W-1:0] vector,
    output logic [DEPTH*ELEM_W-1:0] matrix,
    output logic                    vec_valid,
    output logic [5:0]              fill_count,
    input  logic [ELEM_W-1:0]       data_in,
    output logic [ELEM_W-1:0]       res_data,
    output logic                    res_valid,
    output logic [15:0]             res_count
);
    localparam int W = DEPTH * ELEM_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    fill_vec, fill_mat;
    logic [W-1:0]    nxt_vec, nxt_mat;
    logic            accept, launch;
    logic [RESULT_LAT:0] tok;

    assign in_bus.in_ready = reset && !clear;
    assign accept = in_bus.in_valid && in_bus.in_ready;
    assign launch = accept && (fill_count == 6'(DEPTH - 1));

    // Fill buffer with the current element merged in, so a launch
    // publishes element DEPTH-1 on the same edge that accepts it.
    always_comb begin
        nxt_vec = fill_vec;
        nxt_mat = fill_mat;
        nxt_vec[int'(fill_count)*ELEM_W +: ELEM_W] = in_bus.in_vec;
        nxt_mat[int'(fill_count)*ELEM_W +: ELEM_W] = in_bus.in_mat;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = FILL;
            FILL: if (clear || launch) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            fill_count <= '0;
            fill_vec   <= '0;
            fill_mat   <= '0;
            vector     <= '0;
            matrix     <= '0;
            vec_valid  <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_valid <= launch;
            if (clear) begin
                fill_count <= '0;
                fill_vec   <= '0;
                fill_mat   <= '0;
            end else if (launch) begin
                fill_count <= '0;
                fill_vec   <= '0;
                fill_mat   <= '0;
                vector     <= nxt_vec;
                matrix     <= nxt_mat;
            end else if (accept) begin
                fill_count <= fill_count + 6'd1;
                fill_vec   <= nxt_vec;
                fill_mat   <= nxt_mat;
            end
        end
    end

    // Launch tokens ride this line; clear leaves them alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tok       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            res_count <= '0;
        end else begin
            tok       <= {tok[RESULT_LAT-1:0], launch};
            res_valid <= tok[RESULT_LAT];
            if (tok[RESULT_LAT]) begin
                res_data  <= data_in;
                res_count <= res_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/vecmat32_loader.md
VECMAT32_LOADER -- requirements
Module: vecmat32_loader

Interface
REQ-001 Parameter ELEM_W, 16, width of one fixed-point element.
REQ-002 Parameter DEPTH, 32, elements per operand set.
REQ-003 Parameter RESULT_LAT, 3, edges from operand update to valid data_out of the downstream vecmat32 dot-product stage; legal range 1..31.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-low; reset asserted when low, sampled on clk.
REQ-006 clear  in  1  discard partial fill.
REQ-007 in_valid  in  1  element pair offered.
REQ-008 in_ready  out  1  element pair accepted when in_valid and in_ready are both high at an edge.
REQ-009 in_vec  in  16  softmax element.
REQ-010 in_mat  in  16  matching V-matrix element.
REQ-011 vector  out  512  packed softmax operand to the dot-product stage.
REQ-012 matrix  out  512  packed V operand to the dot-product stage.
REQ-013 vec_valid  out  1  one-cycle pulse: new operand set on vector/matrix.
REQ-014 fill_count  out  6  elements held in the fill buffer, 0..31.
REQ-015 data_in  in  16  data_out of the dot-product stage.
REQ-016 res_data  out  16  captured dot-product result.
REQ-017 res_valid  out  1  one-cycle pulse: res_data updated.
REQ-018 res_count  out  16  results delivered since reset, wraps 0xFFFF->0.

Function
REQ-019 Fill buffer: accepted element k (k = fill_count before the edge) written to fill bits [16k+:16] of the vector and matrix halves; first element after reset/clear/launch is index 0.
REQ-020 in_ready = reset high AND clear low; no other backpressure, since the downstream stage never stalls.
REQ-021 FSM states: IDLE (fill_count 0), FILL (1..31). IDLE->FILL on an accept; FILL->FILL on an accept with fill_count<31; FILL->IDLE on the accept with fill_count 31 (launch) or on clear.
REQ-022 Launch edge: the edge accepting element 31 loads vector/matrix with the full set, including element 31, resets fill_count to 0 and sets vec_valid high for exactly the following cycle.
REQ-023 vector/matrix hold their value between launches; partial fills never reach them.
REQ-024 Back-to-back sets (in_valid held high) launch every 32 cycles with no bubble.
REQ-025 clear high at an edge: fill_count to 0, fill contents discarded, any coincident element dropped (in_ready low). vector/matrix and in-flight results are unaffected.
REQ-026 Result tracker: RESULT_LAT+1 stage shift register of launch tokens. Launch at edge T -> at edge T+RESULT_LAT+1, res_data <= data_in, res_valid high for the following cycle, res_count +1.
REQ-027 Multiple tokens may be in flight. Each launch yields exactly one res_valid pulse, in launch order. clear does not cancel tokens.
REQ-028 No arithmetic on data; res_data is a bit-exact copy of data_in at the capture edge.

Reset
REQ-029 reset low at an edge: fill_count 0, state IDLE, fill buffer 0, vector 0, matrix 0, vec_valid 0, tracker tokens cleared, res_data 0, res_valid 0, res_count 0.
REQ-030 Reset mid-fill or with tokens in flight: partial set and pending results lost. No res_valid until a new launch completes.
REQ-031 in_ready low throughout reset.

Verification
REQ-032 Single set: 32 accepts with in_vec=k, in_mat=0x0100+k (k=0..31) -> vector[16k+:16]=k and matrix[16k+:16]=0x0100+k after edge 32. vec_valid high one cycle; fill_count 0.
REQ-033 Gapped input: in_valid toggled 1/0 for 64 cycles -> one launch only, after the 32nd accept. Earlier operands stay unchanged meanwhile.
REQ-034 Clear: 10 accepts, clear one cycle with in_valid high, then 32 accepts of 0x7FFF -> all 32 slots 0x7FFF. The dropped element is absent; fill_count reads 0 after the clear.
REQ-035 Result timing: launch at edge T, model data_in=0x1234 valid from edge T+3 -> res_data=0x1234, res_valid pulse after edge T+4, res_count=1.
REQ-036 Streaming: 4 back-to-back sets -> 4 vec_valid pulses 32 cycles apart, 4 res_valid pulses each RESULT_LAT+1 edges after its launch, res_count=4.
REQ-037 Reset mid-fill: 20 accepts, reset low one cycle -> all outputs at REQ-029 values. The next 32 accepts produce a set containing only the new elements.
